// File: rtl/dut_clock_sequencer_pkg.sv
// rtl/dut_clock_sequencer_pkg.sv - shared state encoding and parameter defaults
// Purpose: state enum for the clock sequencer FSM and default parameter values.
// Ports: none (package).
package dut_clock_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_IDLE = 2'd2,
    ST_STEP = 2'd3
  } seq_state_e;

  localparam int DEF_DIV_W       = 16;
  localparam int DEF_DELAY_BIT   = 15;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/dut_clock_sequencer_input_sync.sv
// rtl/dut_clock_sequencer_input_sync.sv - multi-flop synchroniser for async inputs
// Purpose: bring an asynchronous level into the clk domain through STAGES flops.
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, clears every stage
//   d     - asynchronous input
//   q     - synchronised output (last stage)
module input_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dut_clock_sequencer.sv
// rtl/dut_clock_sequencer.sv - divided DUT clock with reset, run and single-step control
// Purpose: generates clk_dut from CLK by a programmable divider and sequences the
//   DUT reset (HOLD), free-run (RUN), stopped (IDLE) and single-period (STEP) modes.
// Ports:
//   CLK      - board clock, all logic on posedge
//   rst_n    - asynchronous active-low reset
//   soft_rst - async button, requests a DUT reset sequence
//   run      - async level, 1 = free-run clk_dut
//   step     - async button, each rising edge requests one clk_dut period from IDLE
//   div_val  - half-period minus 1 in CLK cycles
//   clk_dut  - divided DUT clock
//   rst_dut  - active-high DUT reset
//   dut_rise - one-CLK pulse in the cycle clk_dut becomes 1
//   state    - current FSM state
module dut_clock_sequencer
  import dut_clock_sequencer_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DELAY_BIT   = DEF_DELAY_BIT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             soft_rst,
  input  logic             run,
  input  logic             step,
  input  logic [DIV_W-1:0] div_val,
  output logic             clk_dut,
  output logic             rst_dut,
  output logic             dut_rise,
  output logic [1:0]       state
);

  localparam logic [DIV_W-1:0]   CNT_ONE = 1;
  localparam logic [DELAY_BIT:0] DLY_ONE = 1;

  logic soft_s, run_s, step_s;

  input_sync #(.STAGES(SYNC_STAGES)) u_sync_soft (.clk(CLK), .rst_n(rst_n), .d(soft_rst), .q(soft_s));
  input_sync #(.STAGES(SYNC_STAGES)) u_sync_run  (.clk(CLK), .rst_n(rst_n), .d(run),      .q(run_s));
  input_sync #(.STAGES(SYNC_STAGES)) u_sync_step (.clk(CLK), .rst_n(rst_n), .d(step),     .q(step_s));

  seq_state_e           state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_lat_q, div_lat_d;
  logic [DELAY_BIT:0]   delay_q, delay_d;
  logic                 clk_q, clk_d;
  logic                 rst_dut_q, rst_dut_d;
  logic                 rise_q, rise_d;
  logic                 step_prev_q, step_prev_d;

  logic [DIV_W-1:0]     eff_lat;
  logic                 wrap;
  logic                 step_edge;

  // div_val is only sampled at the start of a half-period, so a change
  // mid-half never shortens or stretches the half already in progress.
  assign eff_lat   = (cnt_q == '0) ? div_val : div_lat_q;
  assign wrap      = (cnt_q == eff_lat);
  assign step_edge = step_s & ~step_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = wrap ? '0 : cnt_q + CNT_ONE;
    div_lat_d   = eff_lat;
    delay_d     = delay_q;
    clk_d       = clk_q;
    rst_dut_d   = rst_dut_q;
    step_prev_d = step_s;

    if (soft_s) begin
      state_d   = ST_HOLD;
      cnt_d     = '0;
      delay_d   = '0;
      clk_d     = 1'b0;
      rst_dut_d = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          rst_dut_d = 1'b1;
          if (!delay_q[DELAY_BIT]) delay_d = delay_q + DLY_ONE;
          if (wrap) begin
            clk_d = ~clk_q;
            // Leave reset only on a falling toggle so the DUT starts from clk low.
            if (clk_q && delay_q[DELAY_BIT]) begin
              rst_dut_d = 1'b0;
              state_d   = run_s ? ST_RUN : ST_IDLE;
            end
          end
        end
        ST_RUN: begin
          if (wrap) begin
            clk_d = ~clk_q;
            if (clk_q && !run_s) state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (run_s) begin
            state_d = ST_RUN;
          end else if (step_edge) begin
            // The step period begins with its high half straight away.
            state_d = ST_STEP;
            clk_d   = 1'b1;
          end
        end
        ST_STEP: begin
          if (wrap) begin
            if (clk_q) begin
              clk_d = 1'b0;
            end else if (run_s) begin
              state_d = ST_RUN;
              clk_d   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end

    rise_d = clk_d & ~clk_q;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      div_lat_q   <= '0;
      delay_q     <= '0;
      clk_q       <= 1'b0;
      rst_dut_q   <= 1'b1;
      rise_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_lat_q   <= div_lat_d;
      delay_q     <= delay_d;
      clk_q       <= clk_d;
      rst_dut_q   <= rst_dut_d;
      rise_q      <= rise_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign clk_dut  = clk_q;
  assign rst_dut  = rst_dut_q;
  assign dut_rise = rise_q;
  assign state    = state_q;

endmodule

// File: tb/tb_dut_clock_sequencer.sv
// tb/tb_dut_clock_sequencer.sv - directed self-checking bench for dut_clock_sequencer
module tb_dut_clock_sequencer;

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_IDLE = 2'd2;
  localparam logic [1:0] S_STEP = 2'd3;

  logic        CLK;
  logic        rst_n;
  logic        soft_rst;
  logic        run;
  logic        step;
  logic [15:0] div_val;
  logic        clk_dut;
  logic        rst_dut;
  logic        dut_rise;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  dut_clock_sequencer #(
    .DIV_W(16),
    .DELAY_BIT(3),
    .SYNC_STAGES(2)
  ) u_dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .soft_rst(soft_rst),
    .run(run),
    .step(step),
    .div_val(div_val),
    .clk_dut(clk_dut),
    .rst_dut(rst_dut),
    .dut_rise(dut_rise),
    .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_rise(input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dut_rise && n < max_cyc);
  endtask

  initial begin
    int n;
    int rises;
    int stepc;
    int total_rises;
    bit saw_step;

    rst_n = 1'b0; soft_rst = 1'b0; run = 1'b1; step = 1'b0; div_val = 16'd1;
    repeat (3) @(negedge CLK);
    check("reset_state", state, S_HOLD);
    check("reset_clk_dut", clk_dut, 0);
    check("reset_rst_dut", rst_dut, 1);
    check("reset_dut_rise", dut_rise, 0);

    // Power-on HOLD with div_val=1: reset released on the 12th edge.
    rst_n = 1'b1;
    n = 0; rises = 0;
    while (rst_dut && n < 40) begin
      tick(); n++;
      if (dut_rise) rises++;
    end
    check("hold_exit_cycles", n, 12);
    check("hold_rises", rises, 3);
    check("hold_to_run_state", state, S_RUN);
    check("hold_exit_clk_low", clk_dut, 0);
    wait_rise(20, n);
    check("run_first_rise", n, 2);
    wait_rise(20, n);
    check("run_period_div1", n, 4);

    // div_val=2 adopted from the next half; drop run while clk_dut is high.
    div_val = 16'd2;
    wait_rise(20, n);
    check("run_period_div2", n, 6);
    run = 1'b0;
    n = 0;
    while (clk_dut && n < 20) begin tick(); n++; end
    check("stop_high_half", n, 3);
    check("stop_state_idle", state, S_IDLE);
    rises = 0;
    repeat (10) begin tick(); if (dut_rise) rises++; end
    check("idle_no_rise", rises, 0);
    check("idle_clk_low", clk_dut, 0);

    // Three single steps at div_val=0.
    div_val = 16'd0;
    total_rises = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      rises = 0; stepc = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        step = 1'b0;
        if (dut_rise) rises++;
        if (state == S_STEP) stepc++;
      end
      total_rises += rises;
      check($sformatf("step%0d_rises", k), rises, 1);
      check($sformatf("step%0d_cycles", k), stepc, 2);
      check($sformatf("step%0d_idle", k), state, S_IDLE);
    end
    check("step_total_rises", total_rises, 3);

    // Second step edge arriving during STEP is dropped.
    div_val = 16'd3;
    rises = 0; stepc = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) step = 1'b1;
      if (i == 1) step = 1'b0;
      if (i == 3) step = 1'b1;
      if (i == 5) step = 1'b0;
      tick();
      if (dut_rise) rises++;
      if (state == S_STEP) stepc++;
    end
    check("step_ignore_rises", rises, 1);
    check("step_ignore_cycles", stepc, 8);
    check("step_ignore_idle", state, S_IDLE);

    // run and step rising together: RUN wins.
    run = 1'b1; step = 1'b1;
    saw_step = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (state == S_STEP) saw_step = 1'b1;
    end
    step = 1'b0;
    check("run_step_no_step", saw_step, 0);
    check("run_step_state", state, S_RUN);

    // Soft reset in RUN.
    wait_rise(30, n);
    check("soft_pre_rise_seen", dut_rise, 1);
    soft_rst = 1'b1;
    repeat (3) tick();
    check("soft_state_hold", state, S_HOLD);
    check("soft_rst_dut", rst_dut, 1);
    check("soft_clk_low", clk_dut, 0);
    rises = 0;
    repeat (5) begin tick(); if (dut_rise) rises++; end
    check("soft_held_no_rise", rises, 0);
    check("soft_held_state", state, S_HOLD);
    soft_rst = 1'b0; div_val = 16'd1;
    n = 0;
    while (rst_dut && n < 40) begin tick(); n++; end
    check("soft_release_cycles", n, 14);
    check("soft_release_state", state, S_RUN);

    // div_val change mid-half: current high half keeps the old length.
    wait_rise(20, n);
    check("post_soft_first_rise", n, 2);
    tick();
    div_val = 16'd4;
    n = 1;
    while (clk_dut && n < 20) begin tick(); n++; end
    check("div_change_old_half", n, 2);
    wait_rise(20, n);
    check("div_change_new_half", n, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
